// File: rtl/hazard_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_redirect_ctrl
//
// Fetch-control block for the 5-stage core.
// - Detects load-use hazards between the decode and execute stages and
//   stalls fetch/decode for LOAD_LAT cycles.
// - Turns a taken branch/jump resolved in execute into a one-cycle PC write.
//   It then holds flush for FLUSH_DEPTH further cycles so that wrong-path
//   fetch/decode slots are replaced by NOP.
//
// Ports:
//   clk, rstn           core clock, asynchronous active-low reset
//   id_valid/rs1/rs2    decode-stage instruction and its source indices
//   id_use_rs1/rs2      decode instruction actually reads rs1 / rs2
//   ex_valid/rd         execute-stage instruction and its destination index
//   ex_is_load          execute instruction is a load
//   ex_redirect/target  execute resolved a taken branch/jump to target
//   hazard              stall: fetch holds pc, decode holds instruction
//   pc_write            load pc_write_data as the next pc on this edge
//   pc_write_data       word-aligned redirect target (holds when idle)
//   flush               replace fetch/decode contents with NOP
//   misalign            one-cycle registered pulse after a redirect whose
//                       target had non-zero low bits
//
// Optional build macro HAZARD_STATS_EN:
//   stat_clr            synchronous clear of both statistics counters
//   stall_cycles        saturating count of cycles with hazard=1
//   flush_cycles        saturating count of cycles with flush=1
// ---------------------------------------------------------------------------
module hazard_redirect_ctrl #(
  parameter int FLUSH_DEPTH = 2,
  parameter int LOAD_LAT    = 1,
  parameter int CNT_W       = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_valid,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  output logic        hazard,
  output logic        pc_write,
  output logic [31:0] pc_write_data,
  output logic        flush,
`ifdef HAZARD_STATS_EN
  input  logic        stat_clr,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles,
`endif
  output logic        misalign
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_DEPTH);
  localparam logic [CNT_W-1:0] STALL_INIT = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_pc_data;
  logic               r_misalign;

  logic               w_luse;
  logic               w_redir;
  logic               w_accept;
  logic [31:0]        w_target_al;

  assign w_luse = ex_valid & ex_is_load & (ex_rd != 5'd0) & id_valid &
                  ((id_use_rs1 & (id_rs1 == ex_rd)) |
                   (id_use_rs2 & (id_rs2 == ex_rd)));
  assign w_redir     = ex_valid & ex_redirect;
  // Redirects seen while flushing come from wrong-path slots and are dropped.
  assign w_accept    = w_redir & (r_state != ST_FLUSH);
  assign w_target_al = {ex_target[31:2], 2'b00};

  // NOTE: every output gets a default before the case so no path leaves a
  // signal unassigned; otherwise synthesis infers latches.
  always_comb begin
    hazard   = 1'b0;
    pc_write = 1'b0;
    flush    = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        if (w_redir) begin
          pc_write = 1'b1;
          flush    = 1'b1;
        end else if (w_luse) begin
          hazard = 1'b1;
        end
      end
      ST_STALL: begin
        if (w_redir) begin
          pc_write = 1'b1;
          flush    = 1'b1;
        end else begin
          hazard = 1'b1;
        end
      end
      ST_FLUSH: flush = 1'b1;
      default: ;
    endcase
  end

  // Target goes out in the redirect cycle itself; otherwise hold the last one.
  assign pc_write_data = pc_write ? w_target_al : r_pc_data;
  assign misalign      = r_misalign;

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values, matching flip-flop behaviour in simulation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_RUN;
      r_cnt      <= '0;
      r_pc_data  <= '0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_accept & (ex_target[1:0] != 2'b00);
      if (w_accept) begin
        r_pc_data <= w_target_al;
      end

      unique case (r_state)
        ST_RUN, ST_STALL: begin
          if (w_redir) begin
            if (FLUSH_DEPTH > 0) begin
              r_state <= ST_FLUSH;
              r_cnt   <= FLUSH_INIT;
            end else begin
              r_state <= ST_RUN;
              r_cnt   <= '0;
            end
          end else if (r_state == ST_STALL) begin
            r_cnt <= r_cnt - CNT_ONE;
            if (r_cnt == CNT_ONE) begin
              r_state <= ST_RUN;
            end
          end else if (w_luse && (LOAD_LAT > 1)) begin
            // The RUN cycle is the first stall cycle; STALL covers the rest.
            r_state <= ST_STALL;
            r_cnt   <= STALL_INIT;
          end
        end
        ST_FLUSH: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_cnt   <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_cycles;

  // Clear has priority over increment; both counters saturate.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_cycles <= '0;
      r_flush_cycles <= '0;
    end else if (stat_clr) begin
      r_stall_cycles <= '0;
      r_flush_cycles <= '0;
    end else begin
      if (hazard && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (flush && (r_flush_cycles != 32'hFFFF_FFFF)) begin
        r_flush_cycles <= r_flush_cycles + 32'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_cycles = r_flush_cycles;
`endif

endmodule
